two_digit_display: RTL and testbench
====================================

Name: two_digit_display

Overview:
- Drives a 2-digit multiplexed common-anode 7-segment display showing a 4-bit binary value (0–15) as decimal 00–15.
- Sits at the output of the traffic-light controller and shows the countdown/phase value.
- Performs binary-to-decimal split, segment decoding and time-multiplexed anode scanning with registered outputs.

Parameters:
- REFRESH_CYCLES, 4: clocks each digit stays selected before the scan switches. Legal range ≥1; use ~100000 on hardware.
- BLANK_LEADING_ZERO, 1: when 1, the tens digit is blanked for values 0–9; when 0, it shows '0'.

Ports:
- clk, input, 1: system clock, rising edge active.
- rstn, input, 1: asynchronous active-low reset.
- value, input, 4: unsigned binary value to display, 0–15.
- seg, output, 7: segment drive {g,f,e,d,c,b,a}, active-low; registered.
- an, output, 2: digit enables, active-low; an[0] = units digit, an[1] = tens digit; registered.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset is asynchronous on the falling edge of rstn and released synchronously to clk.
- Reset state
  - Refresh counter = 0; digit select sel = 0 (units).
  - seg = 7'h7F (all off); an = 2'b11 (no digit enabled).
- Digit split (combinational)
  - tens = 1 if value ≥ 10, else 0.
  - units = value − 10 if value ≥ 10, else value.
  - No other values are possible from a 4-bit input.
- Refresh counter
  - Counts 0..REFRESH_CYCLES−1.
  - At terminal count it wraps to 0 and sel toggles; otherwise it increments and sel holds.
  - With REFRESH_CYCLES = 1, sel toggles every clock.
- Output registers (updated every clock from the current sel and value)
  - sel = 0: an <= 2'b10; seg <= pattern(units).
  - sel = 1: an <= 2'b01; seg <= pattern(tens), or 7'h7F when BLANK_LEADING_ZERO = 1 and value < 10.
  - Exactly one of an[1:0] is low at any time after the first post-reset edge.
- Latency
  - A value change appears on seg at the first rising edge at which the relevant digit is selected; one-clock register delay, no other pipelining.
- Segment patterns (active-low, 7'h hex)
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - blank = 7F
  - A decoder default (unreachable) yields 7F.
- Scan sequence from reset release
  - First REFRESH_CYCLES edges: units selected.
  - Next REFRESH_CYCLES edges: tens selected; repeats indefinitely.
  - Each digit is active for exactly REFRESH_CYCLES consecutive clocks.
- Value change mid-scan
  - Takes effect on the next edge without disturbing counter or sel.
- Reset asserted mid-operation
  - Immediately forces seg = 7F, an = 11, counter = 0, sel = 0 regardless of clock.
- Data path
  - No handshake; value is sampled every clock; value is assumed synchronous to clk.

Test Plan:
- Reset: rstn = 0 for 3 clocks with value = 0 → seg = 7F, an = 11 throughout. After release, first edge → an = 10, seg = 40. Tens slot → an = 01, seg = 7F (blanked).
- value = 5, REFRESH_CYCLES = 4, observed over 10+ clocks → units slot: an = 10, seg = 12. Tens slot: an = 01, seg = 7F. Each slot lasts exactly 4 clocks.
- value = 9 → units seg = 10, tens blank. Repeat with BLANK_LEADING_ZERO = 0 → tens seg = 40.
- value = 12 → units slot seg = 24 (2); tens slot seg = 79 (1). value = 15 → units seg = 12 (5), tens seg = 79.
- Change value from 9 to 12 in the middle of a units slot → seg updates to 24 on the next edge. Counter phase and an sequence are unchanged.
- Assert rstn = 0 asynchronously mid-slot (between edges) → seg = 7F and an = 11 immediately. After release, the scan restarts at units for a full REFRESH_CYCLES.

Source files
------------

// File: rtl/two_digit_display.sv
// two_digit_display
//   Drives a 2-digit multiplexed common-anode 7-segment display. The 4-bit
//   input value (0-15) is shown as decimal 00-15. The input is split into
//   tens and units digits, each digit is decoded to segments, and the two
//   digits are scanned in turn.
//
// Parameters
//   REFRESH_CYCLES     : clocks each digit stays selected (>= 1)
//   BLANK_LEADING_ZERO : 1 = tens digit dark for values 0-9, 0 = shows '0'
//
// Ports
//   clk   : system clock, rising edge active
//   rstn  : asynchronous active-low reset
//   value : unsigned value to display, 0-15
//   seg   : segments {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit enables, active-low, registered (an[0] units, an[1] tens)
module two_digit_display #(
  parameter int REFRESH_CYCLES     = 4,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] value,
  output logic [6:0] seg,
  output logic [1:0] an
);

  // A single-clock slot still needs a 1-bit counter so the vector is legal.
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic             sel_r;
  logic [3:0]       tens_s;
  logic [3:0]       units_s;
  logic [6:0]       seg_next_s;
  logic [1:0]       an_next_s;

  // Binary-to-decimal split: a 4-bit input has at most one ten.
  always_comb begin
    tens_s  = 4'd0;
    units_s = value;
    if (value >= 4'd10) begin
      tens_s  = 4'd1;
      units_s = value - 4'd10;
    end else begin
      tens_s  = 4'd0;
      units_s = value;
    end
  end

  // Next segment / anode drive for the digit selected this clock.
  always_comb begin
    seg_next_s = SEG_BLANK;
    an_next_s  = 2'b11;
    if (sel_r == 1'b0) begin
      an_next_s  = 2'b10;
      seg_next_s = seg_pattern(units_s);
    end else begin
      an_next_s = 2'b01;
      if (BLANK_LEADING_ZERO && (value < 4'd10)) begin
        seg_next_s = SEG_BLANK;
      end else begin
        seg_next_s = seg_pattern(tens_s);
      end
    end
  end

  // Refresh counter and digit select; sel flips when the counter wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
      sel_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      sel_r <= ~sel_r;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      sel_r <= sel_r;
    end
  end

  // Registered display outputs, dark while in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg <= SEG_BLANK;
      an  <= 2'b11;
    end else begin
      seg <= seg_next_s;
      an  <= an_next_s;
    end
  end

endmodule

// File: tb/tb_two_digit_display.sv
// tb_two_digit_display
//   Directed bench. Two instances share clock, reset and value:
//     dut  : REFRESH_CYCLES = 4, leading zero blanked
//     dut1 : REFRESH_CYCLES = 1, leading zero shown
//   Expected segment patterns are hand-computed per step; the bench tracks
//   the number of edges since reset release to know which digit is selected.
module tb_two_digit_display;

  logic       clk;
  logic       rstn;
  logic [3:0] value;
  logic [6:0] seg;
  logic [1:0] an;
  logic [6:0] seg1;
  logic [1:0] an1;

  int total_cnt;
  int pass_cnt;
  int k;

  two_digit_display #(.REFRESH_CYCLES(4), .BLANK_LEADING_ZERO(1'b1)) dut (
    .clk(clk), .rstn(rstn), .value(value), .seg(seg), .an(an)
  );

  two_digit_display #(.REFRESH_CYCLES(1), .BLANK_LEADING_ZERO(1'b0)) dut1 (
    .clk(clk), .rstn(rstn), .value(value), .seg(seg1), .an(an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, k);
  endtask

  task automatic check_dark();
    check("rst_seg",  seg,  7'h7F);
    check("rst_an",   {5'd0, an},  7'h03);
    check("rst_seg1", seg1, 7'h7F);
    check("rst_an1",  {5'd0, an1}, 7'h03);
  endtask

  // n edges; u = units pattern, tb = tens pattern when blanking enabled,
  // tn = tens pattern when leading zero shown.
  task automatic run(input int n, input logic [6:0] u, input logic [6:0] tb,
                     input logic [6:0] tn);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      if ((((k - 1) / 4) % 2) == 0) begin
        check("an_units",  {5'd0, an}, 7'h02);
        check("seg_units", seg, u);
      end else begin
        check("an_tens",  {5'd0, an}, 7'h01);
        check("seg_tens", seg, tb);
      end
      if ((k % 2) == 1) begin
        check("an1_units",  {5'd0, an1}, 7'h02);
        check("seg1_units", seg1, u);
      end else begin
        check("an1_tens",  {5'd0, an1}, 7'h01);
        check("seg1_tens", seg1, tn);
      end
    end
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    k         = 0;
    rstn      = 1'b0;
    value     = 4'd0;

    // Held in reset for three clocks: display stays dark.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_dark();
    end

    @(negedge clk);
    rstn = 1'b1;
    k    = 0;

    // value 0: units '0', tens blank (dut) / '0' (dut1)
    run(8, 7'h40, 7'h7F, 7'h40);
    // value 5
    value = 4'd5;
    run(8, 7'h12, 7'h7F, 7'h40);
    // value 9
    value = 4'd9;
    run(8, 7'h10, 7'h7F, 7'h40);
    // value 12: units '2', tens '1'
    value = 4'd12;
    run(8, 7'h24, 7'h79, 7'h79);
    // value 15: units '5', tens '1'
    value = 4'd15;
    run(8, 7'h12, 7'h79, 7'h79);

    // Mid-slot change 9 -> 12 inside a units slot of dut (edges 41..44).
    value = 4'd9;
    run(2, 7'h10, 7'h7F, 7'h40);
    value = 4'd12;
    run(6, 7'h24, 7'h79, 7'h79);

    // Asynchronous reset between edges forces the display dark at once.
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_dark();
    @(negedge clk);
    check_dark();
    rstn = 1'b1;
    k    = 0;

    // Scan restarts at units for a full slot.
    run(8, 7'h24, 7'h79, 7'h79);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
